bram_mul_arbiter: RTL and testbench
===================================

BRAM_MUL_ARBITER -- requirements
Module: bram_mul_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 4, operand width.
REQ-002 SHALL have parameter MUL_WIDTH, 25, DSP A-port width.
REQ-003 SHALL have parameter BRAM_WIDTH, 18, BRAM data width and DSP B-port width.
REQ-004 SHALL have parameter BRAM_ADDR, 12, BRAM address width.
REQ-005 SHALL have parameter DSP_LAT, 1, DSP register stages (0 allowed).
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have ports req0_valid in 1, req0_a in DATA_WIDTH, req0_b in DATA_WIDTH, req0_ready out 1: requester 0.
REQ-009 SHALL have ports req1_valid, req1_a, req1_b, req1_ready, same widths and directions: requester 1.
REQ-010 SHALL have ports rsp_valid out 1, rsp_id out 1, rsp_data out 2*DATA_WIDTH, rsp_ready in 1: result channel.
REQ-011 SHALL have ports wrA out 1, dinA out BRAM_WIDTH, addrA out BRAM_ADDR, doutA in BRAM_WIDTH: BRAM port A, operand store.
REQ-012 SHALL have ports wrB out 1, dinB out BRAM_WIDTH, addrB out BRAM_ADDR: BRAM port B, result log.
REQ-013 SHALL have ports A out MUL_WIDTH, B out BRAM_WIDTH, C in MUL_WIDTH+BRAM_WIDTH: DSP multiplier.

Function
REQ-014 SHALL implement FSM IDLE -> WRITE -> READ -> LOAD -> MUL -> RESP -> IDLE, one transaction in flight.
REQ-015 IDLE: SHALL grant one valid requester; reqN_ready SHALL be 1 only in IDLE, combinationally, for the granted requester; other ready and all ready outside IDLE SHALL be 0.
REQ-016 Arbitration SHALL be round-robin: both valid -> grant priority pointer; pointer SHALL move to the other requester after each completed response; pointer = req0 after reset.
REQ-017 One valid -> SHALL grant it regardless of pointer; none valid -> SHALL stay IDLE.
REQ-018 Accept (valid&ready) SHALL latch a, b, id and go to WRITE.
REQ-019 WRITE (1 cycle): wrA=1, addrA=slot, dinA[DATA_WIDTH-1:0]=a, dinA[9+DATA_WIDTH-1:9]=b, other bits 0.
REQ-020 READ (1 cycle): wrA=0, addrA=slot; BRAM read latency is 1 cycle.
REQ-021 LOAD: SHALL register A=zero-extended doutA[DATA_WIDTH-1:0], B=zero-extended doutA[9+DATA_WIDTH-1:9].
REQ-022 MUL: SHALL wait DSP_LAT+1 cycles (counter), then capture rsp_data=C[2*DATA_WIDTH-1:0].
REQ-023 RESP: rsp_valid=1, rsp_id=latched id; wrB=1 and dinB=zero-extended product, addrB=64+slot in the first RESP cycle only.
REQ-024 rsp_valid, rsp_id, rsp_data SHALL hold stable until rsp_ready=1; the handshake cycle SHALL advance slot and pointer and return to IDLE.
REQ-025 rsp_valid SHALL rise exactly 5+DSP_LAT cycles after the accept edge.
REQ-026 Slot SHALL be 6 bits (addresses 0..63), wrapping 63 -> 0; result address 64..127.
REQ-027 No new request SHALL be accepted while rsp_valid=1 and rsp_ready=0.
REQ-028 A requester dropping valid before ready SHALL cause no side effect.
REQ-029 A and B SHALL keep their last values outside LOAD.

Reset
REQ-030 rst_n=0 SHALL asynchronously force state IDLE, slot 0, pointer req0, wrA=wrB=0, dinA=dinB=0, addrA=addrB=0, A=B=0, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-031 Reset mid-transaction SHALL discard it with no response and no further BRAM write.
REQ-032 Operation SHALL start on the first rising clk edge after rst_n deasserts.

Verification
REQ-033 req0 a=3 b=5 -> wrA addrA=0 dinA=0x0A03; rsp_valid 6 cycles after accept, rsp_data=15, rsp_id=0; wrB addrB=64 dinB=0x00F.
REQ-034 Both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; slots 0,1,2,3.
REQ-035 a=15 b=15 -> rsp_data=225 (0xE1), no truncation.
REQ-036 rsp_ready=0 for 10 cycles with req1 pending -> rsp held stable, req1_ready=0, wrB pulses once.
REQ-037 65 sequential transactions -> 65th writes addrA=0, addrB=64.
REQ-038 rst_n low during MUL -> all outputs zero immediately, no rsp_valid; next request uses slot 0 and is granted to req0 if both valid.

Source files
------------

// File: rtl/bram_mul_arbiter.sv
// Two-requester round-robin front end that stages operands through BRAM and multiplies them on a DSP.
// Latency: rsp_valid rises 5+DSP_LAT cycles after the accept edge; one transaction in flight at a time.
// Backpressure: requesters are only ready in IDLE; the response holds until rsp_ready, blocking new grants.
module bram_mul_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int MUL_WIDTH  = 25,
    parameter int BRAM_WIDTH = 18,
    parameter int BRAM_ADDR  = 12,
    parameter int DSP_LAT    = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    // requester 0
    input  logic                            req0_valid,
    input  logic [DATA_WIDTH-1:0]           req0_a,
    input  logic [DATA_WIDTH-1:0]           req0_b,
    output logic                            req0_ready,
    // requester 1
    input  logic                            req1_valid,
    input  logic [DATA_WIDTH-1:0]           req1_a,
    input  logic [DATA_WIDTH-1:0]           req1_b,
    output logic                            req1_ready,
    // result channel
    output logic                            rsp_valid,
    output logic                            rsp_id,
    output logic [2*DATA_WIDTH-1:0]         rsp_data,
    input  logic                            rsp_ready,
    // BRAM port A: operand store
    output logic                            wrA,
    output logic [BRAM_WIDTH-1:0]           dinA,
    output logic [BRAM_ADDR-1:0]            addrA,
    input  logic [BRAM_WIDTH-1:0]           doutA,
    // BRAM port B: result log
    output logic                            wrB,
    output logic [BRAM_WIDTH-1:0]           dinB,
    output logic [BRAM_ADDR-1:0]            addrB,
    // DSP multiplier
    output logic [MUL_WIDTH-1:0]            A,
    output logic [BRAM_WIDTH-1:0]           B,
    input  logic [MUL_WIDTH+BRAM_WIDTH-1:0] C
);

    localparam int SLOT_W = 6;
    localparam int CNT_W  = $clog2(DSP_LAT + 2) + 1;
    // b sits at bit 9 of the operand word so a and b never overlap for any DATA_WIDTH <= 9
    localparam int B_LSB  = 9;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        LOAD  = 3'd3,
        MUL   = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t                  state_q;
    logic [SLOT_W-1:0]       slot_q;
    logic                    ptr_q;
    logic                    id_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    wrA_q;
    logic [BRAM_WIDTH-1:0]   dinA_q;
    logic [BRAM_ADDR-1:0]    addrA_q;
    logic                    wrB_q;
    logic [BRAM_WIDTH-1:0]   dinB_q;
    logic [BRAM_ADDR-1:0]    addrB_q;
    logic [MUL_WIDTH-1:0]    A_q;
    logic [BRAM_WIDTH-1:0]   B_q;
    logic                    rsp_valid_q;
    logic                    rsp_id_q;
    logic [2*DATA_WIDTH-1:0] rsp_data_q;

    logic                    grant_id_d;
    logic                    accept_d;
    logic [BRAM_WIDTH-1:0]   word_d;
    logic [2*DATA_WIDTH-1:0] prod_d;

    // Only part of the BRAM word and DSP product is meaningful; the rest is deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{doutA, C};

    // Round-robin grant: pointer breaks ties, a lone requester always wins
    always_comb begin
        grant_id_d = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        req0_ready = (state_q == IDLE) && req0_valid && !grant_id_d;
        req1_ready = (state_q == IDLE) && req1_valid &&  grant_id_d;
        accept_d   = req0_ready || req1_ready;
    end

    // Pack the granted operands into one BRAM word, and take the low product bits from the DSP
    always_comb begin
        word_d = '0;
        word_d[DATA_WIDTH-1:0]           = grant_id_d ? req1_a : req0_a;
        word_d[B_LSB+DATA_WIDTH-1:B_LSB] = grant_id_d ? req1_b : req0_b;
        prod_d = C[2*DATA_WIDTH-1:0];
    end

    // Transaction FSM with all BRAM, DSP and response outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            slot_q      <= '0;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            cnt_q       <= '0;
            wrA_q       <= 1'b0;
            dinA_q      <= '0;
            addrA_q     <= '0;
            wrB_q       <= 1'b0;
            dinB_q      <= '0;
            addrB_q     <= '0;
            A_q         <= '0;
            B_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        id_q    <= grant_id_d;
                        wrA_q   <= 1'b1;
                        dinA_q  <= word_d;
                        addrA_q <= BRAM_ADDR'(slot_q);
                        state_q <= WRITE;
                    end
                end
                WRITE: begin
                    // Same slot stays on addrA so READ fetches what was just written
                    wrA_q   <= 1'b0;
                    state_q <= READ;
                end
                READ: begin
                    state_q <= LOAD;
                end
                LOAD: begin
                    A_q     <= MUL_WIDTH'(doutA[DATA_WIDTH-1:0]);
                    B_q     <= BRAM_WIDTH'(doutA[B_LSB+DATA_WIDTH-1:B_LSB]);
                    cnt_q   <= '0;
                    state_q <= MUL;
                end
                MUL: begin
                    // One cycle of margin beyond the DSP pipeline before sampling C
                    if (cnt_q == CNT_W'(DSP_LAT + 1)) begin
                        rsp_data_q  <= prod_d;
                        rsp_valid_q <= 1'b1;
                        rsp_id_q    <= id_q;
                        wrB_q       <= 1'b1;
                        dinB_q      <= BRAM_WIDTH'(prod_d);
                        addrB_q     <= BRAM_ADDR'({1'b1, slot_q});
                        state_q     <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    // Result log write is a single pulse even if the response stalls
                    wrB_q <= 1'b0;
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        slot_q      <= slot_q + SLOT_W'(1);
                        // Tie priority passes to the requester that was not just served
                        ptr_q       <= ~id_q;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wrA       = wrA_q;
    assign dinA      = dinA_q;
    assign addrA     = addrA_q;
    assign wrB       = wrB_q;
    assign dinB      = dinB_q;
    assign addrB     = addrB_q;
    assign A         = A_q;
    assign B         = B_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_bram_mul_arbiter.sv
module tb_bram_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [7:0]  rsp_data;
    logic        wrA, wrB;
    logic [17:0] dinA, doutA, dinB;
    logic [11:0] addrA, addrB;
    logic [24:0] A;
    logic [17:0] B;
    logic [42:0] C;

    int n_tests = 0;
    int n_fail  = 0;

    bram_mul_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
        .wrA(wrA), .dinA(dinA), .addrA(addrA), .doutA(doutA),
        .wrB(wrB), .dinB(dinB), .addrB(addrB),
        .A(A), .B(B), .C(C)
    );

    always #5 clk = ~clk;

    // BRAM model: port A read/write with 1-cycle read latency, port B write-only
    logic [17:0] mem [0:4095];
    always @(posedge clk) begin
        if (wrA) mem[addrA] <= dinA;
        doutA <= mem[addrA];
        if (wrB) mem[addrB] <= dinB;
    end

    // DSP model with one register stage
    always @(posedge clk) C <= 43'(A) * 43'(B);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one transaction from a negedge with request inputs already driven; returns at a negedge
    task automatic txn(input logic exp_id, input int exp_slot, input logic [3:0] ea, input logic [3:0] eb,
                       input int exp_prod, input int hold, input bit drop);
        int k;
        int wrb_cnt;
        rsp_ready = 1'b0;
        #1;
        k = 0;
        while (!(req0_ready || req1_ready) && k < 20) begin
            @(negedge clk); #1;
            k++;
        end
        if (k >= 20) begin
            check("grant_timeout", k, 0);
            return;
        end
        check("grant_id", req1_ready, exp_id);
        check("grant_one", req0_ready & req1_ready, 0);
        @(posedge clk);
        @(negedge clk);
        if (drop) begin
            req0_valid = 1'b0;
            req1_valid = 1'b0;
        end
        check("write_wrA", wrA, 1);
        check("write_addrA", addrA, exp_slot);
        check("write_dinA", dinA, {5'b0, eb, 5'b0, ea});
        k = 0;
        while (!rsp_valid && k < 30) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check("read_wrA", wrA, 0);
                check("read_addrA", addrA, exp_slot);
            end
            if (k == 3) begin
                check("load_A", A, ea);
                check("load_B", B, eb);
                check("busy_ready", req0_ready | req1_ready, 0);
            end
        end
        check("rsp_latency", k, 6);
        if (!rsp_valid) return;
        check("rsp_id", rsp_id, exp_id);
        check("rsp_data", rsp_data, exp_prod);
        check("log_wrB", wrB, 1);
        check("log_addrB", addrB, 64 + exp_slot);
        check("log_dinB", dinB, exp_prod);
        wrb_cnt = 1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_data", rsp_data, exp_prod);
            check("hold_id", rsp_id, exp_id);
            check("hold_ready", req0_ready | req1_ready, 0);
            if (wrB) wrb_cnt++;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        if (wrB) wrb_cnt++;
        check("rsp_done", rsp_valid, 0);
        check("wrB_once", wrb_cnt, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ta, tb;
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wrA", wrA, 0);
        check("rst_wrB", wrB, 0);
        check("rst_addrA", addrA, 0);
        check("rst_addrB", addrB, 0);
        check("rst_dinA", dinA, 0);
        check("rst_dinB", dinB, 0);
        check("rst_AB", {A, B} == '0, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_ready", req0_ready | req1_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single request: 3*5, BRAM word 0x0A03, result logged at 64
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        txn(1'b0, 0, 4'd3, 4'd5, 15, 0, 1'b1);
        check("t1_dinA_const", dinA, 18'h00A03);

        // Lone req1 wins; full-scale operands 15*15 = 225
        req1_valid = 1'b1; req1_a = 4'd15; req1_b = 4'd15;
        txn(1'b1, 1, 4'd15, 4'd15, 225, 0, 1'b1);

        // Both valid continuously: grants alternate starting with req0
        req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd3;
        req1_valid = 1'b1; req1_a = 4'd7; req1_b = 4'd4;
        txn(1'b0, 2, 4'd2, 4'd3, 6, 0, 1'b0);
        txn(1'b1, 3, 4'd7, 4'd4, 28, 0, 1'b0);
        txn(1'b0, 4, 4'd2, 4'd3, 6, 0, 1'b0);
        txn(1'b1, 5, 4'd7, 4'd4, 28, 0, 1'b0);
        // Response stalled 10 cycles with req1 pending
        txn(1'b0, 6, 4'd2, 4'd3, 6, 10, 1'b0);
        txn(1'b1, 7, 4'd7, 4'd4, 28, 0, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset during MUL discards the transaction
        @(negedge clk);
        req1_valid = 1'b1; req1_a = 4'd6; req1_b = 4'd6;
        #1;
        check("mr_grant1", req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mr_in_mul_A", A, 6);
        rst_n = 1'b0;
        #1;
        check("mr_A", A, 0);
        check("mr_B", B, 0);
        check("mr_wr", {wrA, wrB}, 0);
        check("mr_din", {dinA, dinB} == '0, 1);
        check("mr_addr", {addrA, addrB} == '0, 1);
        check("mr_rsp", {rsp_valid, rsp_id, rsp_data}, 0);
        repeat (2) @(negedge clk);
        check("mr_no_rsp", rsp_valid | wrB, 0);
        rst_n = 1'b1;
        @(negedge clk);
        req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd5;
        req1_valid = 1'b1; req1_a = 4'd9; req1_b = 4'd9;
        txn(1'b0, 0, 4'd3, 4'd5, 15, 0, 1'b1);

        // 64 more sequential transactions: the 65th since reset wraps back to slot 0
        for (int i = 0; i < 64; i++) begin
            ta = 4'(i);
            tb = 4'(i * 3 + 1);
            req0_valid = 1'b1; req0_a = ta; req0_b = tb;
            txn(1'b0, (i + 1) % 64, ta, tb, int'(ta) * int'(tb), 0, 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
